// File: rtl/product_accumulator_4bits.sv
// product_accumulator_4bits
//   Back end of the 4-bit multiplier. It takes a stream of unsigned products
//   over a valid/ready handshake and adds len_cfg+1 of them into one frame sum.
//   The frame sum and a sticky overflow flag are presented over an output
//   valid/ready handshake.
//
//   Build option:
//     ACC_SATURATE_EN  defined   -> on overflow the accumulator clamps to all-ones
//                                   and stays there for the rest of the frame
//                      undefined -> the accumulator wraps modulo 2^ACC_WIDTH
//   In both builds overflow is sticky for the frame.
module product_accumulator_4bits #(
  parameter int PROD_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] product,
  input  logic [LEN_WIDTH-1:0]  len_cfg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic                  overflow,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  state_t                 state;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   acc_ovf;
  logic [LEN_WIDTH-1:0]   remaining;

  logic                   accept;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH:0]     add_full;
  logic [ACC_WIDTH-1:0]   acc_nxt;
  logic                   ovf_nxt;

  // Handshake strobes. in_ready/busy decode straight off the state register,
  // so in_ready is already high while reset is asserted.
  assign in_ready = (state != DONE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;

  // Product zero-extended to accumulator width; the add is one bit wider so
  // the carry out of the accumulator range is visible as the overflow bit.
  assign prod_ext = ACC_WIDTH'(product);
  assign add_full = {1'b0, acc} + (ACC_WIDTH + 1)'(product);

  // Next accumulator value and sticky overflow for an accepted ACCUM beat.
  always_comb begin
    ovf_nxt = acc_ovf | add_full[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
    // Once the frame has overflowed, hold the clamp even if later adds fit.
    acc_nxt = ovf_nxt ? {ACC_WIDTH{1'b1}} : add_full[ACC_WIDTH-1:0];
`else
    acc_nxt = add_full[ACC_WIDTH-1:0];
`endif
  end

  // Frame FSM: IDLE takes the first beat, ACCUM adds the rest, and DONE holds
  // the registered result until downstream takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      acc_ovf   <= 1'b0;
      remaining <= '0;
      sum       <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // len_cfg is only looked at here; later changes within the frame are ignored.
            acc       <= prod_ext;
            acc_ovf   <= 1'b0;
            remaining <= len_cfg;
            if (len_cfg == '0) begin
              state     <= DONE;
              sum       <= prod_ext;
              overflow  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc       <= acc_nxt;
            acc_ovf   <= ovf_nxt;
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state     <= DONE;
              sum       <= acc_nxt;
              overflow  <= ovf_nxt;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // No beat is taken in this cycle. The next frame starts one cycle later, from IDLE.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator_4bits.sv
// tb_product_accumulator_4bits
//   Scoreboard bench. The frame driver computes the expected sum and overflow
//   for each frame and pushes them when it drives the frame. The monitor pops
//   and compares whenever a result is taken. The DUT is built with
//   ACC_WIDTH=10 so that the overflow case is reachable.
module tb_product_accumulator_4bits;

  localparam int PW = 8;
  localparam int AW = 10;
  localparam int LW = 4;
  localparam int AMAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] product;
  logic [LW-1:0] len_cfg;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] sum;
  logic          overflow;
  logic          busy;

  typedef struct {
    int sum;
    int ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   npush  = 0;
  int   npop   = 0;
  int   fp[16];

  product_accumulator_4bits #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .product(product), .len_cfg(len_cfg),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // Monitor: a result is taken on the coming edge when out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        npop++;
        chk("sum", int'(sum), e.sum);
        chk("ovf", int'(overflow), e.ovf);
      end
    end
  end

  // One beat: inputs change 1 time unit after a rising edge. The beat is
  // accepted at the first edge where in_ready is high.
  task automatic beat(input int p, input int l);
    int n;
    n = 0;
    product  = PW'(p);
    len_cfg  = LW'(l);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("beat_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Reference model of a frame: the first product loads the sum, later ones
  // add to it, and the sum either wraps or saturates at AW bits.
  task automatic frame(input int len, input int gap, input int lchg);
    exp_t e;
    int   a;
    int   o;
    a = fp[0];
    o = 0;
    for (int i = 1; i <= len; i++) begin
      a = a + fp[i];
      if (a > AMAX) begin
        o = 1;
`ifdef ACC_SATURATE_EN
        a = AMAX;
`else
        a = a - (AMAX + 1);
`endif
      end
    end
    e.sum = a;
    e.ovf = o;
    q.push_back(e);
    npush++;
    for (int i = 0; i <= len; i++) begin
      beat(fp[i], (i == 0) ? len : lchg);
      if (i != len) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
      end
    end
    // The result is visible in the cycle after the last accept.
    chk("latency", int'(out_valid), 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    product   = '0;
    len_cfg   = '0;
    out_ready = 1'b1;
    idle_cycles(2);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    idle_cycles(1);

    // Three back-to-back beats.
    fp[0] = 6; fp[1] = 30; fp[2] = 130;
    frame(2, 0, 2);
    idle_cycles(2);
    chk("idle_after3", int'(busy), 0);

    // Single beat with the result held by backpressure.
    out_ready = 1'b0;
    fp[0] = 225;
    frame(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      product  = 8'd99;
      @(posedge clk); #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_sum", int'(sum), 225);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_busy", int'(busy), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    chk("bp_release_busy", int'(busy), 0);

    // Overflow: five beats of 225 give 1125 against a 10-bit sum.
    for (int i = 0; i < 5; i++) fp[i] = 225;
    frame(4, 0, 4);
    idle_cycles(1);

    // Bubble cycles between beats, with len_cfg dropped to 0 after the first beat.
    fp[0] = 1; fp[1] = 2; fp[2] = 3; fp[3] = 4;
    frame(3, 1, 0);
    idle_cycles(1);

    // Reset mid-frame drops the partial frame.
    beat(5, 3);
    beat(6, 3);
    reset = 1'b1;
    #1;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_in_ready", int'(in_ready), 1);
    chk("mrst_sum", int'(sum), 0);
    chk("mrst_ovf", int'(overflow), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(3);
    chk("mrst_no_result", int'(out_valid), 0);
    fp[0] = 7;
    frame(0, 0, 0);
    idle_cycles(1);

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      int len;
      len = int'($urandom_range(0, 15));
      for (int i = 0; i <= len; i++) fp[i] = int'($urandom_range(0, 255));
      frame(len, int'($urandom_range(0, 2)), int'($urandom_range(0, 15)));
    end

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sb_drain", q.size(), 0);
    chk("frames", npop, npush);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator_4bits.md
Name: product_accumulator_4bits

Overview:
Downstream stage of multiplier_4bits_version13. It consumes the 8-bit product stream through a valid/ready handshake and sums a programmable number of products (1..16) into a wide accumulator. It then presents the sum with an overflow flag through an output valid/ready handshake. The result is a sequential dot-product/MAC back end built on the combinational multiplier.

Parameters:
PROD_WIDTH, 8, width of incoming product (2x multiplier operand width)
ACC_WIDTH, 16, accumulator/sum width; must be >= PROD_WIDTH
LEN_WIDTH, 4, width of len_cfg; frame length = len_cfg + 1 (1..2^LEN_WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  product beat valid
in_ready  output  1  stage can accept a beat
product  input  PROD_WIDTH  unsigned product from multiplier
len_cfg  input  LEN_WIDTH  frame length minus one; sampled on first beat of a frame only
out_valid  output  1  sum available
out_ready  input  1  downstream accepts sum
sum  output  ACC_WIDTH  accumulated frame sum
overflow  output  1  frame sum exceeded ACC_WIDTH range at any beat
busy  output  1  frame in progress (state != IDLE)

Behaviour:
- One clock; asynchronous active-high reset, as already decided.
- Reset values: state=IDLE, accumulator=0, remaining count=0, sum=0, overflow=0, out_valid=0, busy=0. in_ready=1 once reset is deasserted.
- A beat is accepted when in_valid & in_ready at a rising edge. A result is taken when out_valid & out_ready.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: in_ready=1.
  - On accept: acc<=product (zero-extended), overflow<=0, remaining<=len_cfg.
  - If len_cfg==0, go to DONE; otherwise go to ACCUM.
- ACCUM: in_ready=1.
  - On accept: acc<=acc+product, remaining<=remaining-1.
  - If remaining==1 at accept, go to DONE.
  - No accept: hold all state. Bubbles on in_valid are legal.
- DONE: in_ready=0, out_valid=1. sum and overflow are driven from registers and stay stable while out_valid is high.
  - On out_ready: go to IDLE, out_valid<=0.
  - A new frame cannot start in the same cycle as the sum is taken. The next beat is accepted the cycle after.
- Latency: out_valid rises on the clock edge that accepts the last beat, i.e. it is visible in the cycle after the last accept. Throughput is N+1 cycles per frame minimum with out_ready held high.
- Width rule: addition is computed at ACC_WIDTH+1 bits. When bit ACC_WIDTH is set:
  - overflow is set sticky for the frame;
  - acc takes the low ACC_WIDTH bits (wrap).
- in_valid during DONE is not accepted. The upstream must hold it, per valid/ready rules.
- len_cfg changes mid-frame are ignored.
- product and in_valid are don't-care when in_ready=0.
- Reset asserted mid-frame or in DONE discards the frame immediately (asynchronous). No partial sum is emitted.
- out_ready while out_valid=0 has no effect.

Optional Feature:
Macro ACC_SATURATE_EN.
- Defined: on overflow, acc clamps to all-ones (2^ACC_WIDTH-1) and stays clamped for the rest of the frame. overflow is set the same way.
- Undefined: acc wraps modulo 2^ACC_WIDTH. overflow is still set.

Test Plan:
- Reset, then idle: reset pulse mid-sim -> in_ready=1, out_valid=0, sum=0, overflow=0, busy=0 immediately on reset assertion.
- Three-beat frame: len_cfg=2; products 6, 30, 130 (from 2x3, 10x3, 13x10), back-to-back -> out_valid one cycle after third accept; sum=166, overflow=0.
- Single-beat frame with backpressure:
  - len_cfg=0, product=225 -> DONE with sum=225.
  - Hold out_ready=0 for 5 cycles -> sum and out_valid stable; in_ready=0; offered beat not accepted.
  - Assert out_ready -> IDLE next cycle.
- Overflow, ACC_WIDTH=10, len_cfg=4, five beats of 225 (total 1125):
  - Without ACC_SATURATE_EN -> sum=101, overflow=1.
  - With ACC_SATURATE_EN -> sum=1023, overflow=1.
- Bubbles and len_cfg change: len_cfg=3; beats 1, 2, 3, 4 with in_valid low on alternating cycles; len_cfg changed to 0 after first beat -> sum=10 after the 4th accept only.
- Reset mid-frame: len_cfg=3, accept 2 beats, assert reset -> no out_valid. A following frame with len_cfg=0 and product 7 gives sum=7, overflow=0.
